// File: rtl/vga_timing_pkg.sv
// Shared constants and elaboration helpers for the VGA timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz-class pixel rate.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_CNT_W    = 16;

  // Length of a full line or frame from its four timing segments.
  function automatic int unsigned timing_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic bit timing_nonzero(input int unsigned ha, input int unsigned hf,
                                        input int unsigned hs, input int unsigned hb,
                                        input int unsigned va, input int unsigned vf,
                                        input int unsigned vs, input int unsigned vb);
    return (ha != 0) && (hf != 0) && (hs != 0) && (hb != 0) &&
           (va != 0) && (vf != 0) && (vs != 0) && (vb != 0);
  endfunction

  // True when a cnt_w-bit counter can reach the largest terminal count.
  function automatic bit cnt_w_fits(input int unsigned cnt_w,
                                    input int unsigned h_total,
                                    input int unsigned v_total);
    longint unsigned max_cnt;
    max_cnt = 64'(h_total > v_total ? h_total : v_total) - 64'd1;
    if (cnt_w == 0) return 1'b0;
    if (cnt_w >= 63) return 1'b1;
    return (64'd1 << cnt_w) > max_cnt;
  endfunction

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulo-N counter with enable; exposes its next value so the parent can
// register derived outputs in step with the count.
module wrap_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned MODULUS = 800,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt_c,
  output logic             wrap_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

  if (MODULUS == 0 || !cnt_w_fits(CNT_W, MODULUS, MODULUS)) begin : g_bad_modulus
    $error("wrap_counter: MODULUS must be non-zero and fit in CNT_W bits");
  end

  logic at_last_c;

  assign at_last_c = (count == LAST);
  assign wrap_c    = en & at_last_c;

  always_comb begin
    count_nxt_c = count;
    if (en) begin
      count_nxt_c = at_last_c ? '0 : count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nxt_c;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, sync pulses, display enable,
// active-area coordinates and end-of-line/frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_end,
  output logic             frame_end
);

  localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_STOP  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_STOP  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if (!timing_nonzero(H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP))
  begin : g_bad_zero
    $error("vga_timing_gen: every timing parameter must be non-zero");
  end

  if (!cnt_w_fits(CNT_W, H_TOTAL, V_TOTAL)) begin : g_bad_width
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  logic [CNT_W-1:0] h_nxt_c;
  logic [CNT_W-1:0] v_nxt_c;
  logic             h_wrap_c;
  logic             v_wrap_c;

  wrap_counter #(
    .MODULUS (H_TOTAL),
    .CNT_W   (CNT_W)
  ) u_h_counter (
    .clk         (clk),
    .rst         (rst),
    .en          (ce),
    .count       (h_cnt),
    .count_nxt_c (h_nxt_c),
    .wrap_c      (h_wrap_c)
  );

  // Vertical counter steps once per horizontal wrap, so both wrap together at frame end.
  wrap_counter #(
    .MODULUS (V_TOTAL),
    .CNT_W   (CNT_W)
  ) u_v_counter (
    .clk         (clk),
    .rst         (rst),
    .en          (h_wrap_c),
    .count       (v_cnt),
    .count_nxt_c (v_nxt_c),
    .wrap_c      (v_wrap_c)
  );

  logic             hsync_nxt_c;
  logic             vsync_nxt_c;
  logic             de_nxt_c;
  logic [CNT_W-1:0] x_nxt_c;
  logic [CNT_W-1:0] y_nxt_c;

  // Decode from next counts so registered outputs line up with h_cnt/v_cnt.
  always_comb begin
    hsync_nxt_c = ~HS_POL;
    vsync_nxt_c = ~VS_POL;
    de_nxt_c    = 1'b0;
    x_nxt_c     = '0;
    y_nxt_c     = '0;
    if (h_nxt_c >= HS_START && h_nxt_c < HS_STOP) begin
      hsync_nxt_c = HS_POL;
    end
    if (v_nxt_c >= VS_START && v_nxt_c < VS_STOP) begin
      vsync_nxt_c = VS_POL;
    end
    if (h_nxt_c < H_ACT && v_nxt_c < V_ACT) begin
      de_nxt_c = 1'b1;
      x_nxt_c  = h_nxt_c;
      y_nxt_c  = v_nxt_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      de    <= 1'b1;
      x     <= '0;
      y     <= '0;
    end else begin
      hsync <= hsync_nxt_c;
      vsync <= vsync_nxt_c;
      de    <= de_nxt_c;
      x     <= x_nxt_c;
      y     <= y_nxt_c;
    end
  end

  assign line_end  = h_wrap_c & ~rst;
  assign frame_end = v_wrap_c & ~rst;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen: a default 640x480 instance and a
// tiny positive-polarity instance, both against a raster-index model.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } cfg_t;

  typedef struct packed {
    logic [31:0] h, v, x, y;
    logic        hs, vs, de, le, fe;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b1, ce0 = 1'b0, rst1 = 1'b1, ce1 = 1'b0;
  logic [15:0] h0, v0, x0, y0, h1, v1, x1, y1;
  logic        hs0, vs0, de0, le0, fe0, hs1, vs1, de1, le1, fe1;

  vga_timing_gen u_dut0 (
    .clk(clk), .rst(rst0), .ce(ce0), .h_cnt(h0), .v_cnt(v0), .hsync(hs0), .vsync(vs0),
    .de(de0), .x(x0), .y(y0), .line_end(le0), .frame_end(fe0)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(16)
  ) u_dut1 (
    .clk(clk), .rst(rst1), .ce(ce1), .h_cnt(h1), .v_cnt(v1), .hsync(hs1), .vsync(vs1),
    .de(de1), .x(x1), .y(y1), .line_end(le1), .frame_end(fe1)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   pix[2];
  bit   known[2];
  obs_t q0[$];
  obs_t q1[$];
  bit   done0 = 1'b0, done1 = 1'b0;

  function automatic cfg_t cfg_of(input int id);
    cfg_t c;
    if (id == 0) c = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33,
                       hp: 1'b0, vp: 1'b0};
    else         c = '{ha: 4, hf: 1, hs: 2, hb: 1, va: 3, vf: 1, vs: 1, vb: 1,
                       hp: 1'b1, vp: 1'b1};
    return c;
  endfunction

  // Expected outputs for raster index p (p = v*H_TOTAL + h) under the given inputs.
  function automatic obs_t expect_at(input cfg_t c, input int p, input bit ce, input bit rst);
    obs_t o;
    int ht, vt, h, v;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    h  = p % ht;
    v  = p / ht;
    o.h  = 32'(h);
    o.v  = 32'(v);
    o.de = (h < c.ha) && (v < c.va);
    o.x  = o.de ? 32'(h) : 32'd0;
    o.y  = o.de ? 32'(v) : 32'd0;
    o.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
    o.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
    o.le = ce && !rst && (h == ht - 1);
    o.fe = o.le && (v == vt - 1);
    return o;
  endfunction

  function automatic void check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endfunction

  // Drive one cycle of inputs, queue the expected view of the current state, advance the model.
  task automatic step(input int id, input bit ce, input bit rst);
    cfg_t c;
    int   tot;
    c   = cfg_of(id);
    tot = (c.ha + c.hf + c.hs + c.hb) * (c.va + c.vf + c.vs + c.vb);
    if (id == 0) begin ce0 = ce; rst0 = rst; end
    else         begin ce1 = ce; rst1 = rst; end
    if (known[id]) begin
      if (id == 0) q0.push_back(expect_at(c, pix[id], ce, rst));
      else         q1.push_back(expect_at(c, pix[id], ce, rst));
    end
    @(posedge clk);
    if (rst) begin
      pix[id]   = 0;
      known[id] = 1'b1;
    end else if (ce && known[id]) begin
      pix[id] = (pix[id] + 1) % tot;
    end
    #1;
  endtask

  function automatic void compare(input int id, input obs_t e, input obs_t a);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL dut%0d t=%0t got h=%0d v=%0d x=%0d y=%0d hs=%b vs=%b de=%b le=%b fe=%b want h=%0d v=%0d x=%0d y=%0d hs=%b vs=%b de=%b le=%b fe=%b",
               id, $time, a.h, a.v, a.x, a.y, a.hs, a.vs, a.de, a.le, a.fe,
               e.h, e.v, e.x, e.y, e.hs, e.vs, e.de, e.le, e.fe);
    end
  endfunction

  obs_t e0, a0, e1, a1;

  always @(negedge clk) begin
    if (q0.size() != 0) begin
      e0 = q0.pop_front();
      a0.h = 32'(h0); a0.v = 32'(v0); a0.x = 32'(x0); a0.y = 32'(y0);
      a0.hs = hs0; a0.vs = vs0; a0.de = de0; a0.le = le0; a0.fe = fe0;
      compare(0, e0, a0);
    end
    if (q1.size() != 0) begin
      e1 = q1.pop_front();
      a1.h = 32'(h1); a1.v = 32'(v1); a1.x = 32'(x1); a1.y = 32'(y1);
      a1.hs = hs1; a1.vs = vs1; a1.de = de1; a1.le = le1; a1.fe = fe1;
      compare(1, e1, a1);
    end
  end

  // Event counters for pulse-width, strobe-count and strobe-spacing checks.
  bit win_hs0 = 1'b0, win_b0 = 1'b0, win1 = 1'b0;
  int hs_low0 = 0, cyc0 = 0, last_le0 = -1, le_cnt1 = 0, fe_cnt1 = 0;

  always @(negedge clk) begin
    cyc0++;
    if (win_hs0 && hs0 == 1'b0) hs_low0++;
    if (win_b0 && le0) begin
      if (last_le0 >= 0) check("line_end spacing ce/4", cyc0 - last_le0, 3200);
      last_le0 = cyc0;
    end
    if (win1) begin
      le_cnt1 += int'(le1);
      fe_cnt1 += int'(fe1);
    end
  end

  initial begin : drive0
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);
    win_hs0 = 1'b1;
    for (int i = 0; i < 800; i++) step(0, 1'b1, 1'b0);
    win_hs0 = 1'b0;
    check("hsync low cycles per line", hs_low0, 96);
    for (int i = 0; i < 400; i++) step(0, 1'b1, 1'b0);
    check("model at h=400 before reset", pix[0] % 800, 400);
    step(0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(0, 1'b1, 1'b0);
    step(0, 1'b0, 1'b1);
    win_b0 = 1'b1;
    for (int i = 0; i < 13000; i++) step(0, (i % 4) == 0, 1'b0);
    win_b0 = 1'b0;
    for (int i = 0; i < 3000; i++)
      step(0, 1'($urandom_range(1, 0)), $urandom_range(299, 0) == 0);
    done0 = 1'b1;
  end

  initial begin : drive1
    step(1, 1'b0, 1'b1);
    step(1, 1'b0, 1'b1);
    win1 = 1'b1;
    for (int i = 0; i < 480; i++) step(1, 1'b1, 1'b0);
    win1 = 1'b0;
    check("small line_end count in 480 clks", le_cnt1, 60);
    check("small frame_end count in 480 clks", fe_cnt1, 10);
    for (int i = 0; i < 4000; i++)
      step(1, $urandom_range(3, 0) != 0, $urandom_range(99, 0) == 0);
    for (int k = 0; k < 8 && (pix[1] % 8) != 7; k++) step(1, 1'b1, 1'b0);
    step(1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1, 1'b1, 1'b0);
    for (int i = 0; i < 1000; i++)
      step(1, 1'($urandom_range(1, 0)), $urandom_range(199, 0) == 0);
    done1 = 1'b1;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: drivers did not complete, done0=%0d done1=%0d", done0, done1);
    $fatal(1, "timeout");
  end

  initial begin : finish
    wait (done0 && done1);
    repeat (2) @(negedge clk);
    check("scoreboard0 drained", q0.size(), 0);
    check("scoreboard1 drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 Parameter H_FP, default 16, meaning horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, meaning horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, meaning horizontal back porch in pixels; H_TOTAL = sum of the four horizontal parameters (800).
REQ-005 Parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-006 Parameter V_FP, default 10, meaning vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, meaning vertical sync width in lines.
REQ-008 Parameter V_BP, default 33, meaning vertical back porch in lines; V_TOTAL = sum of the four vertical parameters (525).
REQ-009 Parameters HS_POL and VS_POL, default 0, meaning the sync level during the pulse (0 = active-low).
REQ-010 Parameter CNT_W, default 16, meaning the width of every counter and coordinate output.
REQ-011 clk  input  1  the single clock. All logic SHALL be on its rising edge.
REQ-012 rst  input  1  synchronous, active-high reset.
REQ-013 ce  input  1  pixel-rate enable. Counters SHALL advance only on clk edges where ce=1.
REQ-014 h_cnt  output  CNT_W  horizontal position, range 0..H_TOTAL-1.
REQ-015 v_cnt  output  CNT_W  vertical position, range 0..V_TOTAL-1.
REQ-016 hsync, vsync  output  1 each  sync outputs, polarity set by HS_POL and VS_POL.
REQ-017 de  output  1  display enable; high inside the active area.
REQ-018 x, y  output  CNT_W each  active-area coordinates.
REQ-019 line_end  output  1  one-clk strobe at the last pixel of each line.
REQ-020 frame_end  output  1  one-clk strobe at the last pixel of each frame.

Function
REQ-021 On a clk edge with ce=1:
- If h_cnt < H_TOTAL-1, h_cnt SHALL increment by 1.
- Otherwise h_cnt SHALL wrap to 0 and v_cnt SHALL advance; v_cnt wraps from V_TOTAL-1 to 0.
REQ-022 When ce=0, h_cnt, v_cnt, hsync, vsync, de, x and y SHALL hold their values.
REQ-023 hsync, vsync, de, x and y SHALL be registered. They SHALL be computed from the next counter values so that they always match the h_cnt/v_cnt presented in the same cycle (zero relative latency).
REQ-024 Sync windows:
- hsync = HS_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; otherwise hsync = ~HS_POL.
- vsync follows the same rule using the vertical parameters and v_cnt.
REQ-025 de SHALL be 1 exactly when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-026 When de=1, x and y SHALL equal h_cnt and v_cnt. When de=0, x and y SHALL be 0.
REQ-027 Strobes SHALL be combinational from the registered counters and ce:
- line_end = ce AND (h_cnt == H_TOTAL-1).
- frame_end = line_end AND (v_cnt == V_TOTAL-1).
Each strobe is high for exactly one clk cycle per event.
REQ-028 Simultaneous horizontal and vertical wrap, at (H_TOTAL-1, V_TOTAL-1) with ce=1, SHALL produce (0,0) on the next edge with no skipped or duplicated state.
REQ-029 Elaboration SHALL fail if any timing parameter is 0, or if 2^CNT_W <= max(H_TOTAL, V_TOTAL)-1.

Reset
REQ-030 rst=1 at a clk edge SHALL set the outputs, regardless of ce or current position, including mid-line and mid-frame:
- h_cnt = 0 and v_cnt = 0.
- x = 0 and y = 0.
- de = 1.
- hsync = ~HS_POL and vsync = ~VS_POL.
REQ-031 rst SHALL take priority over ce. Counting SHALL resume from (0,0) on the first ce=1 edge after rst deasserts.
REQ-032 line_end and frame_end SHALL be 0 while rst=1.

Structure
REQ-033 Package vga_timing_pkg SHALL hold the 640x480@60 default constants, the H_TOTAL/V_TOTAL derivation helpers and the CNT_W legality check.
REQ-034 A sub-module wrap_counter (inputs: modulus parameter, clk, rst, en; outputs: count and wrap strobe) SHALL be instantiated twice.
- Horizontal instance: en = ce.
- Vertical instance: en = horizontal wrap strobe.

Verification
REQ-035 Defaults, ce tied to 1, 420000 clks after rst: exactly 1 frame_end and 525 line_end. In each line, hsync is low for h_cnt 656..751; in each frame, vsync is low for v_cnt 490..491.
REQ-036 Defaults, ce=1 every 4th clk: h_cnt advances once per 4 clks. line_end occurs every 3200 clks, and all outputs are stable on ce=0 cycles.
REQ-037 Coordinates: at h_cnt=639 and v_cnt=479, de=1, x=639 and y=479. At h_cnt=640, de=0 and x=0, y=0.
REQ-038 Reset at h_cnt=400, v_cnt=300 with ce=1: the next edge gives (0,0), hsync=1 and vsync=1; the following ce edge gives h_cnt=1.
REQ-039 Small instance (H: 4/1/2/1, V: 3/1/1/1, HS_POL=1, VS_POL=1): the period is 8 clks per line and 48 clks per frame. hsync=1 only at h_cnt 5..6; the wrap (7,5) to (0,0) is exact.
